// File: rtl/gshare_predictor.sv
// Gshare branch predictor: 2-bit saturating counters indexed by address XOR global history.
// Each accepted transaction runs IDLE -> PREDICT -> UPDATE, emitting one registered prediction before training.
module gshare_predictor #(
    parameter int ADDR_BITS    = 16,
    parameter int INDEX_BITS   = 4,
    parameter int HISTORY_BITS = 4,
    parameter int STAT_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 data_input_done,
    input  logic [ADDR_BITS-1:0] inst_addr,
    input  logic                 direction_ground_truth,
    output logic                 prediction,
    output logic                 prediction_valid,
    output logic                 prediction_correct,
    output logic [STAT_BITS-1:0] num_predictions,
    output logic [STAT_BITS-1:0] num_correct,
    output logic                 busy
);

    localparam int DEPTH = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREDICT = 2'd1,
        ST_UPDATE  = 2'd2
    } state_t;

    state_t                  state_q;
    logic [1:0]              table_q [DEPTH];
    logic [HISTORY_BITS-1:0] ghr_q;
    logic [INDEX_BITS-1:0]   idx_q;
    logic [INDEX_BITS-1:0]   idx_d;
    logic                    truth_q;
    logic                    prediction_q;
    logic                    valid_q;
    logic                    correct_q;
    logic                    busy_q;
    logic [STAT_BITS-1:0]    num_pred_q;
    logic [STAT_BITS-1:0]    num_corr_q;
    logic [1:0]              entry_rd;
    logic [1:0]              entry_d;
    logic                    unused_addr_bits;

    // Only the low address bits select a counter; the rest are deliberately ignored.
    assign unused_addr_bits = ^inst_addr;

    always_comb begin
        idx_d    = inst_addr[INDEX_BITS-1:0] ^ INDEX_BITS'(ghr_q);
        entry_rd = table_q[idx_q];
        entry_d  = entry_rd;
        if (truth_q && (entry_rd != 2'b11)) begin
            entry_d = entry_rd + 2'd1;
        end else if (!truth_q && (entry_rd != 2'b00)) begin
            entry_d = entry_rd - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= 2'b01;
            end
        end else if (state_q == ST_UPDATE) begin
            table_q[idx_q] <= entry_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ghr_q        <= '0;
            idx_q        <= '0;
            truth_q      <= 1'b0;
            prediction_q <= 1'b0;
            valid_q      <= 1'b0;
            correct_q    <= 1'b0;
            busy_q       <= 1'b0;
            num_pred_q   <= '0;
            num_corr_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (data_input_done) begin
                        idx_q   <= idx_d;
                        truth_q <= direction_ground_truth;
                        state_q <= ST_PREDICT;
                        busy_q  <= 1'b1;
                    end
                end
                ST_PREDICT: begin
                    prediction_q <= entry_rd[1];
                    correct_q    <= (entry_rd[1] == truth_q);
                    valid_q      <= 1'b1;
                    state_q      <= ST_UPDATE;
                    busy_q       <= 1'b1;
                end
                ST_UPDATE: begin
                    ghr_q      <= (ghr_q << 1) | HISTORY_BITS'(truth_q);
                    num_pred_q <= num_pred_q + STAT_BITS'(1);
                    if (correct_q) begin
                        num_corr_q <= num_corr_q + STAT_BITS'(1);
                    end
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    // Unreachable encoding: recover without touching any state.
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign prediction         = prediction_q;
    assign prediction_valid   = valid_q;
    assign prediction_correct = correct_q;
    assign num_predictions    = num_pred_q;
    assign num_correct        = num_corr_q;
    assign busy               = busy_q;

endmodule
